// File: rtl/vga_capture.sv
// VGA receive-side capture: samples hsync/vsync/RGB444 on the pixel clock,
// rebuilds pixel coordinates from sync edges, checks line/frame timing,
// locks onto a clean frame and emits a coordinate-tagged pixel stream.
//
// Ports:
//   vga_clk, resetn           pixel clock, synchronous active-low reset
//   hsync, vsync              active-low syncs from the pins
//   vga_r, vga_g, vga_b       RGB444 colour from the pins
//   err_clr                   pulse, clears err_h / err_v
//   pix_valid/data/x/y        registered active-pixel stream, no backpressure
//   pix_sof, pix_eol          first pixel of frame / last pixel of line
//   locked                    frame timing locked
//   frame_done, frame_sum     pulse + checksum of last complete locked frame
//   err_h, err_v              sticky line-length / frame-length errors
module vga_capture #(
    parameter int H_TOTAL     = 1056,
    parameter int H_ACT_START = 217,
    parameter int H_ACT_END   = 1016,
    parameter int V_TOTAL     = 628,
    parameter int V_ACT_START = 28,
    parameter int V_ACT_END   = 627
) (
    input  logic        vga_clk,
    input  logic        resetn,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [11:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        locked,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic        err_h,
    output logic        err_v
);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] HT  = 11'(H_TOTAL);
    localparam logic [10:0] HT1 = 11'(H_TOTAL + 1);
    localparam logic [10:0] HAS = 11'(H_ACT_START);
    localparam logic [10:0] HAE = 11'(H_ACT_END);
    localparam logic [9:0]  VT  = 10'(V_TOTAL);
    localparam logic [9:0]  VT1 = 10'(V_TOTAL + 1);
    localparam logic [9:0]  VAS = 10'(V_ACT_START);
    localparam logic [9:0]  VAE = 10'(V_ACT_END);

    logic        s_hs, s_vs, s_hs_d, s_vs_d;
    logic [11:0] s_rgb;
    logic        vpend;
    logic [10:0] hx, cur_x;
    logic [9:0]  hy, cur_y;
    logic        h_edge, v_fall, fs;
    logic        chk_en, line_err, frame_err, any_err;
    logic        active, take_sum;
    logic        frame_bad;
    logic [31:0] acc;
    state_t      state, state_next;

    // Input stage and sync edge history
    always_ff @(posedge vga_clk) begin
        if (!resetn) begin
            s_hs   <= 1'b1;
            s_vs   <= 1'b1;
            s_hs_d <= 1'b1;
            s_vs_d <= 1'b1;
            s_rgb  <= 12'd0;
        end else begin
            s_hs   <= hsync;
            s_vs   <= vsync;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            s_rgb  <= {vga_r, vga_g, vga_b};
        end
    end

    // Position of the sample currently in the input stage
    always_comb begin
        h_edge = s_hs_d & ~s_hs;
        v_fall = s_vs_d & ~s_vs;
        fs     = h_edge & (vpend | v_fall);
        if (h_edge)
            cur_x = 11'd1;
        else if (hx == 11'h7FF)
            cur_x = hx;
        else
            cur_x = hx + 11'd1;
        cur_y = hy;
        if (h_edge) begin
            if (fs)
                cur_y = 10'd1;
            else if (hy != 10'h3FF)
                cur_y = hy + 10'd1;
        end
    end

    // Timing checks; the overlong-line check fires only on the one
    // clock where the count passes H_TOTAL.
    always_comb begin
        chk_en    = (state != UNLOCK);
        line_err  = chk_en & ((h_edge & (hx != HT)) |
                              (~h_edge & (cur_x == HT1)));
        frame_err = chk_en & ((fs & (hy != VT)) |
                              (h_edge & ~fs & (cur_y == VT1)));
        any_err   = line_err | frame_err;
        active    = (cur_x >= HAS) && (cur_x <= HAE) &&
                    (cur_y >= VAS) && (cur_y <= VAE);
        take_sum  = (state == LOCKED) & fs & ~any_err;
    end

    always_ff @(posedge vga_clk) begin
        if (!resetn) begin
            vpend <= 1'b0;
            hx    <= 11'd0;
            hy    <= 10'd0;
        end else begin
            if (fs)
                vpend <= 1'b0;
            else if (v_fall)
                vpend <= 1'b1;
            hx <= cur_x;
            hy <= cur_y;
        end
    end

    // FSM: state register
    always_ff @(posedge vga_clk) begin
        if (!resetn)
            state <= UNLOCK;
        else
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            UNLOCK: if (fs) state_next = SYNC;
            SYNC:   if (fs && !frame_bad && !any_err) state_next = LOCKED;
            LOCKED: if (any_err) state_next = SYNC;
            default: state_next = UNLOCK;
        endcase
    end

    // FSM: outputs
    always_comb begin
        locked = (state == LOCKED);
    end

    // Records whether the SYNC frame in progress has seen any error
    always_ff @(posedge vga_clk) begin
        if (!resetn) begin
            frame_bad <= 1'b0;
        end else begin
            unique case (state)
                UNLOCK: if (fs) frame_bad <= 1'b0;
                SYNC: begin
                    if (fs)
                        frame_bad <= 1'b0;
                    else if (any_err)
                        frame_bad <= 1'b1;
                end
                LOCKED: if (any_err) frame_bad <= 1'b0;
                default: frame_bad <= 1'b0;
            endcase
        end
    end

    // Checksum: zeroed outside LOCKED, on entry/exit and at each frame start
    always_ff @(posedge vga_clk) begin
        if (!resetn) begin
            acc        <= 32'd0;
            frame_sum  <= 32'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= take_sum;
            if (take_sum)
                frame_sum <= acc;
            if (state != LOCKED || state_next != LOCKED || fs)
                acc <= 32'd0;
            else if (active)
                acc <= acc + {20'd0, s_rgb};
        end
    end

    // Pixel stream
    always_ff @(posedge vga_clk) begin
        if (!resetn || !(locked && active)) begin
            pix_valid <= 1'b0;
            pix_data  <= 12'd0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else begin
            pix_valid <= 1'b1;
            pix_data  <= s_rgb;
            pix_x     <= 10'(cur_x - HAS);
            pix_y     <= cur_y - VAS;
            pix_sof   <= (cur_x == HAS) && (cur_y == VAS);
            pix_eol   <= (cur_x == HAE);
        end
    end

    // Sticky errors; a new error beats a simultaneous clear
    always_ff @(posedge vga_clk) begin
        if (!resetn) begin
            err_h <= 1'b0;
            err_v <= 1'b0;
        end else begin
            if (line_err)
                err_h <= 1'b1;
            else if (err_clr)
                err_h <= 1'b0;
            if (frame_err)
                err_v <= 1'b1;
            else if (err_clr)
                err_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed testbench for vga_capture using a reduced timing geometry,
// with scoreboard queues for the pixel stream and frame checksums.
module tb_vga_capture;

    localparam int HT  = 40;
    localparam int HAS = 9;
    localparam int HAE = 32;
    localparam int VT  = 20;
    localparam int VAS = 4;
    localparam int VAE = 19;

    logic        vga_clk = 1'b0;
    logic        resetn;
    logic        hsync, vsync, err_clr;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        pix_valid, pix_sof, pix_eol, locked, frame_done;
    logic        err_h, err_v;
    logic [11:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic [31:0] frame_sum;

    vga_capture #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_END(VAE)
    ) dut (
        .vga_clk(vga_clk), .resetn(resetn),
        .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .err_clr(err_clr),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol),
        .locked(locked), .frame_done(frame_done),
        .frame_sum(frame_sum), .err_h(err_h), .err_v(err_v)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int          due;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] d;
        logic        sof;
        logic        eol;
    } pix_t;

    typedef struct {
        int          due;
        logic [31:0] sum;
    } done_t;

    pix_t        pq[$];
    done_t       dq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_sum = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h",
                    tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, "_pix_sof"}, 32'(pix_sof), 32'd0);
        chk({tag, "_pix_eol"}, 32'(pix_eol), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_sum"}, frame_sum, 32'd0);
        chk({tag, "_err_h"}, 32'(err_h), 32'd0);
        chk({tag, "_err_v"}, 32'(err_v), 32'd0);
    endtask

    task automatic monitor();
        pix_t  e;
        done_t d;
        if (pix_valid) begin
            if (pq.size() == 0) begin
                chk("pix_spurious", 32'(pix_valid), 32'd0);
            end else begin
                e = pq.pop_front();
                chk("pix_due", 32'(cyc), 32'(e.due));
                chk("pix_x", 32'(pix_x), 32'(e.x));
                chk("pix_y", 32'(pix_y), 32'(e.y));
                chk("pix_data", 32'(pix_data), 32'(e.d));
                chk("pix_sof", 32'(pix_sof), 32'(e.sof));
                chk("pix_eol", 32'(pix_eol), 32'(e.eol));
            end
        end else if (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk("pix_missing", 32'(pix_valid), 32'd1);
        end
        if (frame_done) begin
            if (dq.size() == 0) begin
                chk("done_spurious", 32'(frame_done), 32'd0);
            end else begin
                d = dq.pop_front();
                chk("done_due", 32'(cyc), 32'(d.due));
                chk("frame_sum", frame_sum, d.sum);
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            d = dq.pop_front();
            chk("done_missing", 32'(frame_done), 32'd1);
        end
    endtask

    task automatic tick();
        @(negedge vga_clk);
        cyc++;
        monitor();
    endtask

    // One transmitted frame. out_en: whether this frame's active pixels
    // are expected at the output. err_kind 1/2: an err_h/err_v event is
    // expected at the first edge of this frame.
    task automatic send_frame(input bit out_en, input bit vs_on,
                              input int pat, input int short_y,
                              input int err_kind, input int clr_y,
                              input int clr_x, input int rst_y);
        bit          en;
        bit          full;
        logic [31:0] sum;
        logic [11:0] rgb;
        logic        flag;
        int          len;
        pix_t        p;
        done_t       d;
        en   = out_en;
        full = out_en;
        sum  = 32'd0;
        for (int y = 1; y <= VT; y++) begin
            len = (y == short_y) ? HT - 1 : HT;
            for (int x = 1; x <= len; x++) begin
                tick();
                flag = (err_kind == 1) ? err_h : err_v;
                if (y == 1 && x == 3 && vs_on && err_kind != 2)
                    chk("locked_after_fs", 32'(locked), 32'(out_en));
                if (y == 1 && err_kind != 0 && x == 2) begin
                    chk("err_pre", 32'(flag), 32'd0);
                    chk("locked_pre", 32'(locked), 32'd1);
                end
                if (y == 1 && err_kind != 0 && x == 3) begin
                    chk("err_set", 32'(flag), 32'd1);
                    chk("locked_drop", 32'(locked), 32'd0);
                end
                if (y == clr_y && x == clr_x + 2 && err_kind == 0) begin
                    chk("err_h_cleared", 32'(err_h), 32'd0);
                    chk("err_v_cleared", 32'(err_v), 32'd0);
                end
                if (y == rst_y && x == 16)
                    chk_zero("midreset");
                resetn = !(y == rst_y && x >= 15 && x <= 17);
                if (y == rst_y && x == 15) begin
                    while (pq.size() > 0 && pq[$].due > cyc)
                        void'(pq.pop_back());
                    dq.delete();
                    pend_valid = 1'b0;
                    en   = 1'b0;
                    full = 1'b0;
                end
                err_clr = (y == clr_y && x == clr_x);
                if (pat != 0)
                    rgb = 12'((x - HAS) + (y - VAS));
                else
                    rgb = 12'hABC;
                if (y == 1 && x == 1) begin
                    if (vs_on && pend_valid && err_kind == 0) begin
                        d.due = cyc + 2;
                        d.sum = pend_sum;
                        dq.push_back(d);
                    end
                    pend_valid = 1'b0;
                end
                if (en && x >= HAS && x <= HAE && y >= VAS && y <= VAE) begin
                    p.due = cyc + 2;
                    p.x   = 10'(x - HAS);
                    p.y   = 10'(y - VAS);
                    p.d   = rgb;
                    p.sof = (x == HAS && y == VAS);
                    p.eol = (x == HAE);
                    pq.push_back(p);
                    sum = sum + 32'(rgb);
                end
                hsync = (x <= 4) ? 1'b0 : 1'b1;
                vsync = (vs_on && y <= 2) ? 1'b0 : 1'b1;
                {vga_r, vga_g, vga_b} = rgb;
            end
        end
        pend_valid = full;
        pend_sum   = sum;
    endtask

    initial begin
        resetn  = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        err_clr = 1'b0;
        {vga_r, vga_g, vga_b} = 12'd0;
        repeat (3) tick();
        chk_zero("reset");
        resetn = 1'b1;
        repeat (5) tick();
        chk("idle_locked", 32'(locked), 32'd0);

        // Constant colour: SYNC frame, then locked frames
        send_frame(0, 1, 0, 0, 0, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0, 0, 0, 0);
        chk("clean_err_h", 32'(err_h), 32'd0);
        chk("clean_err_v", 32'(err_v), 32'd0);

        // Ramp pattern
        send_frame(1, 1, 1, 0, 0, 0, 0, 0);
        send_frame(1, 1, 1, 0, 0, 0, 0, 0);

        // Short last line; early edge coincides with err_clr
        send_frame(1, 1, 1, VT, 0, 0, 0, 0);
        send_frame(0, 1, 1, 0, 1, 1, 2, 0);
        send_frame(1, 1, 1, 0, 0, 0, 0, 0);
        chk("err_h_sticky", 32'(err_h), 32'd1);
        send_frame(1, 1, 0, 0, 0, 5, 10, 0);

        // Missing vsync pulse
        send_frame(0, 0, 0, 0, 2, 0, 0, 0);
        send_frame(0, 1, 0, 0, 0, 0, 0, 0);
        send_frame(1, 1, 1, 0, 0, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0, 0, 0, 0);

        // Reset while locked, then re-acquire
        send_frame(1, 1, 1, 0, 0, 0, 0, 8);
        send_frame(0, 1, 1, 0, 0, 0, 0, 0);
        send_frame(1, 1, 1, 0, 0, 0, 0, 0);
        send_frame(1, 1, 0, 0, 0, 0, 0, 0);

        hsync = 1'b1;
        vsync = 1'b1;
        repeat (4) tick();
        chk("pix_queue_drained", 32'(pq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
